ram_256x8: RTL and testbench

//   Single-port synchronous RAM: 256 words x 8 bits, one clock domain.

---
 rtl/ram_pkg.sv | 24 ++
 rtl/ram_clear_seq.sv | 71 +++++++
 rtl/ram_256x8.sv | 88 ++++++++
 tb/tb_ram_256x8.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package    : ram_pkg                                                    |
// | Purpose    : Shared widths, word/address typedefs and clear-sweep state |
// |              encoding for the 256x8 single-port RAM.                    |
// | Revision   : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package ram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Memory-clear sweep sequencer states
  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : ram_clear_seq                                              |
// | Purpose    : After reset, walks every address 0..2**ADDR_W-1 once,      |
// |              one word per cycle, requesting a write of zero to each.    |
// | Ports      : clk      in  clock, rising edge                            |
// |              rst      in  synchronous reset, active low                 |
// |              clr_we   out write request for the sweep                   |
// |              clr_addr out address being cleared                         |
// |              busy     out high while the sweep is running               |
// | Revision   : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  output logic                clr_we,
  output logic [ADDR_W_P-1:0] clr_addr,
  output logic                busy
);

  clr_state_t          r_state, w_state_next;
  logic [ADDR_W_P-1:0] r_cnt,   w_cnt_next;
  // Set by reset so that the first edge with rst=1 launches the sweep;
  // cleared once launched so a finished sweep does not repeat.
  logic                r_armed, w_armed_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_armed <= w_armed_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_armed_next = r_armed;
    case (r_state)
      CLR_IDLE: begin
        if (r_armed) begin
          w_state_next = CLR_RUN;
          w_cnt_next   = '0;
          w_armed_next = 1'b0;
        end
      end
      CLR_RUN: begin
        w_cnt_next = r_cnt + 1'b1;
        // Last word is written on the edge that leaves CLR_RUN
        if (r_cnt == '1) begin
          w_state_next = CLR_IDLE;
        end
      end
      default: w_state_next = CLR_IDLE;
    endcase
  end

  assign clr_we   = (r_state == CLR_RUN);
  assign clr_addr = r_cnt;
  assign busy     = (r_state == CLR_RUN);

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_256x8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : ram_256x8                                                  |
// | Purpose    : Single-port synchronous RAM, 256 x 8, registered read.     |
// |              One access per cycle: write when we=1, else read.          |
// | Ports      : clk      in  clock, rising edge                            |
// |              rst      in  synchronous reset, active low                 |
// |              we       in  write enable (1 write, 0 read)                |
// |              addr     in  word address                                  |
// |              data_in  in  write data                                    |
// |              data_out out registered read data                          |
// |              busy     out clear sweep in progress                       |
// | Config     : RAM_CLEAR_EN - when defined, every reset is followed by a  |
// |              sweep writing zero to all words; otherwise busy is 0.      |
// | Revision   : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module ram_256x8
  import ram_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W_P-1:0] addr,
  input  logic [DATA_W_P-1:0] data_in,
  output logic [DATA_W_P-1:0] data_out,
  output logic                busy
);

  localparam int DEPTH_P = 1 << ADDR_W_P;

  reg [DATA_W_P-1:0] mem [0:DEPTH_P-1];

  logic                w_we;
  logic [ADDR_W_P-1:0] w_addr;
  logic [DATA_W_P-1:0] w_wdata;
  logic                w_busy;

`ifdef RAM_CLEAR_EN
  logic                w_clr_we;
  logic [ADDR_W_P-1:0] w_clr_addr;

  ram_clear_seq #(
    .ADDR_W_P (ADDR_W_P)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .busy     (w_busy)
  );

  // The sweep owns the array while running; the user port is ignored.
  assign w_we    = w_busy ? w_clr_we   : we;
  assign w_addr  = w_busy ? w_clr_addr : addr;
  assign w_wdata = w_busy ? '0         : data_in;
`else
  assign w_busy  = 1'b0;
  assign w_we    = we;
  assign w_addr  = addr;
  assign w_wdata = data_in;
`endif

  // Array has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && w_we) begin
      mem[w_addr] <= w_wdata;
    end
  end

  // Read port: data_out holds across writes (no write-through) and is
  // forced to zero while the clear sweep runs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
    end else if (w_busy) begin
      data_out <= '0;
    end else if (!we) begin
      data_out <= mem[addr];
    end
  end

  assign busy = w_busy;

endmodule : ram_256x8
`default_nettype wire

// File: tb/tb_ram_256x8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : tb_ram_256x8                                               |
// | Purpose    : Directed self-checking bench for ram_256x8.                |
// |              Build with RAM_CLEAR_EN defined to cover the clear sweep.  |
// | Revision   : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_ram_256x8;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;

  int checks;
  int failures;

  ram_256x8 u_dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; data_in = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    we = 1'b0; addr = a;
    cycle();
    check(tag, {8'h00, data_out}, {8'h00, exp});
  endtask

  // Pulse reset for one edge, then (clear build) wait out the sweep.
  task automatic pulse_reset(input string tag);
    int n;
    rst = 1'b0;
    cycle();
    check({tag, "_dout"}, {8'h00, data_out}, 16'h0000);
    check({tag, "_busy"}, {15'h0000, busy}, 16'h0000);
    rst = 1'b1;
`ifdef RAM_CLEAR_EN
    n = 0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (busy) begin
        n++;
        if (data_out !== 8'h00 && n == 10) check({tag, "_dout_busy"}, {8'h00, data_out}, 16'h0000);
      end else begin
        break;
      end
    end
    check({tag, "_busy_cycles"}, n[15:0], 16'd256);
`else
    n = 0;
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; we = 1'b0; addr = 8'h00; data_in = 8'h00;
    cycle();
    cycle();
    check("reset_dout", {8'h00, data_out}, 16'h0000);
    check("reset_busy", {15'h0000, busy}, 16'h0000);
    rst = 1'b1;

`ifdef RAM_CLEAR_EN
    // Sweep launched by the initial reset; user inputs held as garbage writes.
    begin
      int n;
      n = 0;
      we = 1'b1; addr = 8'h80; data_in = 8'hCC;
      for (int i = 0; i < 400; i++) begin
        cycle();
        if (busy) n++;
        else break;
      end
      we = 1'b0;
      check("clr_busy_cycles", n[15:0], 16'd256);
      check("clr_dout_after", {8'h00, data_out}, 16'h0000);
    end
    do_read("clr_rd_00", 8'h00, 8'h00);
    do_read("clr_rd_80", 8'h80, 8'h00);
    do_read("clr_rd_ff", 8'hFF, 8'h00);
`endif

    // Basic writes; data_out must not follow write data
    do_write(8'h00, 8'h01);
    check("no_write_through", {8'h00, data_out}, 16'h0000);
    do_write(8'h01, 8'h02);
    do_write(8'h02, 8'h03);
    do_read("rd_00", 8'h00, 8'h01);
    do_read("rd_01", 8'h01, 8'h02);
    do_read("rd_02", 8'h02, 8'h03);

    // Top address
    do_write(8'hFF, 8'hA5);
    check("write_holds_dout", {8'h00, data_out}, 16'h0003);
    do_read("rd_ff", 8'hFF, 8'hA5);
    do_read("rd_00_again", 8'h00, 8'h01);

    // Mid address, distinct bit pattern
    do_write(8'h80, 8'h5A);
    do_read("rd_80", 8'h80, 8'h5A);

    // Read old value, overwrite, read new value next cycle
    do_read("rd_01_old", 8'h01, 8'h02);
    do_write(8'h01, 8'h77);
    check("overwrite_holds_dout", {8'h00, data_out}, 16'h0002);
    do_read("rd_01_new", 8'h01, 8'h77);

    // Reset while a write to 0x02 is presented: the write is discarded
    we = 1'b1; addr = 8'h02; data_in = 8'hEE;
    pulse_reset("mid_reset");
    we = 1'b0;
`ifdef RAM_CLEAR_EN
    do_read("rd_02_after_reset", 8'h02, 8'h00);
`else
    do_read("rd_02_after_reset", 8'h02, 8'h03);
`endif

    // Stable read address over several edges
    do_write(8'hFF, 8'hC3);
    we = 1'b0; addr = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_rd_ff", {8'h00, data_out}, 16'h00C3);
    end

    check("busy_idle", {15'h0000, busy}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_256x8
`default_nettype wire
